// File: rtl/mer_meas_ctrl.sv
// MER measurement controller: free-running sample/interp/symbol strobes plus a
// settle/measure/done sequencer with a saturating symbol-error count.
// Optional feature macro: MEAS_AUTO_RESTART_EN (ack re-enters MEASURE directly).
module mer_meas_ctrl #(
    parameter int SETTLE_SYMS = 64,
    parameter int MEAS_LOG2   = 10,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
    input  logic             sym_error,
    output logic             smp_en,
    output logic             int_en,
    output logic             sym_en,
    output logic             clear_accum,
    output logic             busy,
    output logic             result_valid,
    output logic [ERR_W-1:0] err_count
);
    localparam int SET_W = $clog2(SETTLE_SYMS + 1);
    localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_SYMS);
    localparam logic [MEAS_LOG2:0] WIN_LAST    = {1'b1, {MEAS_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    state_t             state, state_nxt;
    logic [3:0]         phase;
    logic [SET_W-1:0]   settle_cnt, settle_nxt, settle_inc;
    logic [MEAS_LOG2:0] sym_cnt, sym_nxt, sym_inc;
    logic [ERR_W-1:0]   err_acc, err_nxt, err_count_nxt;
    logic               clear_nxt;

    // Strobes decode the registered phase so every consumer sees aligned edges.
    assign smp_en = (phase[1:0] == 2'd3);
    assign int_en = phase[0];
    assign sym_en = (phase == 4'd15);

    assign busy         = (state == SETTLE) || (state == MEASURE);
    assign result_valid = (state == DONE);

    assign settle_inc = settle_cnt + 1'b1;
    assign sym_inc    = sym_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            state       <= IDLE;
            settle_cnt  <= '0;
            sym_cnt     <= '0;
            err_acc     <= '0;
            err_count   <= '0;
            clear_accum <= 1'b0;
        end else begin
            phase       <= phase + 4'd1;
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            sym_cnt     <= sym_nxt;
            err_acc     <= err_nxt;
            err_count   <= err_count_nxt;
            clear_accum <= clear_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        settle_nxt    = settle_cnt;
        sym_nxt       = sym_cnt;
        err_nxt       = err_acc;
        err_count_nxt = err_count;
        clear_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                if (sym_en) begin
                    settle_nxt = settle_inc;
                    if (settle_inc == SETTLE_LAST) begin
                        state_nxt = MEASURE;
                        sym_nxt   = '0;
                        err_nxt   = '0;
                        clear_nxt = 1'b1;
                    end
                end
            end
            MEASURE: begin
                if (sym_en) begin
                    sym_nxt = sym_inc;
                    if (sym_error && (err_acc != {ERR_W{1'b1}}))
                        err_nxt = err_acc + 1'b1;
                    // Publish the count including this final symbol's error.
                    if (sym_inc == WIN_LAST) begin
                        state_nxt     = DONE;
                        err_count_nxt = err_nxt;
                    end
                end
            end
            DONE: begin
                if (ack) begin
`ifdef MEAS_AUTO_RESTART_EN
                    state_nxt = MEASURE;
                    sym_nxt   = '0;
                    err_nxt   = '0;
                    clear_nxt = 1'b1;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Scoreboard bench for mer_meas_ctrl: directed windows push expected error
// counts; a monitor pops and compares on each result_valid rise.
module tb_mer_meas_ctrl;
    logic       clk, reset, start, ack, sym_error;
    logic       smp_en, int_en, sym_en, clear_accum, busy, result_valid;
    logic [3:0] err_count;
    logic       d2_smp, d2_int, d2_sym, d2_clr, d2_busy, d2_rv;
    logic [1:0] d2_err;
    logic [3:0] ph;

    int passed = 0;
    int total  = 0;
    int q[$];
    int q2[$];
    int e_mon, e_mon2;
    logic rv_q, rv2_q;
    logic [3:0] held;
    logic [1:0] held2;

    mer_meas_ctrl #(.SETTLE_SYMS(4), .MEAS_LOG2(3), .ERR_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack), .sym_error(sym_error),
        .smp_en(smp_en), .int_en(int_en), .sym_en(sym_en), .clear_accum(clear_accum),
        .busy(busy), .result_valid(result_valid), .err_count(err_count)
    );

    // Narrow counter sees errors on every strobe and must saturate at 3.
    mer_meas_ctrl #(.SETTLE_SYMS(4), .MEAS_LOG2(3), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .ack(ack), .sym_error(1'b1),
        .smp_en(d2_smp), .int_en(d2_int), .sym_en(d2_sym), .clear_accum(d2_clr),
        .busy(d2_busy), .result_valid(d2_rv), .err_count(d2_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) ph <= reset ? 4'd0 : ph + 4'd1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (result_valid && !rv_q) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                e_mon = q.pop_front();
                chk("err_count", err_count, e_mon);
            end
            held <= err_count;
        end else if (result_valid) chk("err_count_hold", err_count, held);
        if (d2_rv && !rv2_q) begin
            if (q2.size() == 0) chk("unexpected_result_w2", 1, 0);
            else begin
                e_mon2 = q2.pop_front();
                chk("err_count_w2", d2_err, e_mon2);
            end
            held2 <= d2_err;
        end else if (d2_rv) chk("err_count_hold_w2", d2_err, held2);
        rv_q  <= result_valid;
        rv2_q <= d2_rv;
    end

    // Caller has start=1 at the current negedge so the next edge enters SETTLE.
    task automatic run_window(input logic [7:0] pat, input int exp, input bit between,
                              input bit noise, input int abort_at);
        int strobes = 0;
        int clr_n = 0;
        int clr_at = -1;
        int guard = 0;
        bit rv_early = 0;
        if (abort_at == 0) begin
            q.push_back(exp);
            q2.push_back(3);
        end
        @(negedge clk);
        chk("busy_rise", busy, 1);
        start = noise;
        ack   = noise;
        forever begin
            if (clear_accum) begin clr_n++; clr_at = strobes; end
            if (strobes == 12) break;
            if (result_valid) rv_early = 1;
            if (abort_at > 0 && strobes == abort_at) begin
                start = 0; ack = 0; sym_error = 0;
                reset = 1;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_rv", result_valid, 0);
                chk("abort_clear", clear_accum, 0);
                chk("abort_err_count", err_count, 0);
                chk("abort_err_count_w2", d2_err, 0);
                chk("abort_sym_en", sym_en, 0);
                reset = 0;
                return;
            end
            if (ph == 4'd15) begin
                sym_error = (strobes >= 4) ? pat[strobes-4] : between;
                strobes++;
            end else sym_error = between;
            guard++;
            if (guard > 1000) begin
                chk("window_timeout", 0, 1);
                start = 0; ack = 0; sym_error = 0;
                return;
            end
            @(negedge clk);
        end
        chk("result_valid_rise", result_valid, 1);
        chk("rv_not_early", rv_early, 0);
        chk("busy_done", busy, 0);
        chk("clear_pulses", clr_n, 1);
        chk("clear_after_settle", clr_at, 4);
        start = 0; ack = 0; sym_error = 0;
    endtask

    task automatic do_ack();
        repeat (3) @(negedge clk);
        ack = 1;
        @(negedge clk);
        chk("ack_clears_rv", result_valid, 0);
        chk("ack_to_idle", busy, 0);
        ack = 0;
    endtask

    initial begin
        int n_smp = 0;
        int n_int = 0;
        int n_sym = 0;
        int first = -1;
        reset = 1; start = 0; ack = 0; sym_error = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_clear", clear_accum, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_strobes", {smp_en, int_en, sym_en}, 0);
        chk("rst_w2", {d2_busy, d2_rv, d2_clr, d2_err, d2_smp, d2_int, d2_sym}, 0);
        reset = 0;

        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            n_smp += int'(smp_en);
            n_int += int'(int_en);
            n_sym += int'(sym_en);
            if (sym_en && first < 0) first = i;
        end
        chk("smp_en_count", n_smp, 16);
        chk("int_en_count", n_int, 32);
        chk("sym_en_count", n_sym, 4);
        chk("first_sym_en", first, 15);
        @(negedge clk);

        start = 1;
        run_window(8'h00, 0, 1'b0, 1'b0, 0);
        do_ack();

        start = 1;
        run_window(8'b0100_1010, 3, 1'b1, 1'b1, 0);
        do_ack();

        start = 1;
        run_window(8'hFF, 0, 1'b1, 1'b0, 9);
        @(negedge clk);
        start = 1;
        run_window(8'b1000_0001, 2, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        ack = 1; start = 1;
        @(negedge clk);
`ifdef MEAS_AUTO_RESTART_EN
        chk("restart_busy", busy, 1);
        chk("restart_clear", clear_accum, 1);
        chk("restart_rv", result_valid, 0);
        ack = 0; start = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
`else
        chk("ack_start_rv", result_valid, 0);
        chk("ack_start_idle", busy, 0);
        ack = 0;
        run_window(8'hFF, 8, 1'b0, 1'b0, 0);
        do_ack();
`endif

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("queue_drained_w2", q2.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
